// File: rtl/ddr3_burst_writer.sv
// Avalon-MM burst write master for the DDR3 controller local port.
// Write words are buffered in a show-ahead FIFO; each accepted command emits one burst.
module ddr3_burst_writer #(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 26,
    parameter int MAX_BURST  = 4,
    parameter int SIZE_W     = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                ddr3_clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [SIZE_W-1:0]   cmd_len,
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic [DATA_W/8-1:0] wd_be,
    input  logic                ddr3_avl_ready,
    output logic                ddr3_avl_burstbegin,
    output logic                ddr3_avl_write_req,
    output logic [SIZE_W-1:0]   ddr3_avl_size,
    output logic [ADDR_W-1:0]   ddr3_avl_addr,
    output logic [DATA_W-1:0]   ddr3_avl_wr_data,
    output logic [DATA_W/8-1:0] ddr3_avl_be,
    output logic                busy,
    output logic                wr_done,
    output logic                cmd_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]      MAX_LEN  = MAX_BURST;

    typedef enum logic [1:0] {IDLE, FILL, BURST, DONE} state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic [BE_W-1:0]   mem_be   [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [ADDR_W-1:0] addr_q;
    logic [SIZE_W-1:0] len_q;
    logic [SIZE_W-1:0] beat_cnt;
    logic              cmd_err_q;

    logic push, pop, cmd_fire, len_ok, fill_ok, last_beat;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign wd_ready  = (count != FULL_CNT);
    assign push      = wd_valid & wd_ready;
    assign pop       = ddr3_avl_write_req & ddr3_avl_ready;
    assign cmd_ready = (state == IDLE);
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign len_ok    = (cmd_len != '0) && (32'(cmd_len) <= MAX_LEN);
    assign fill_ok   = (32'(count) >= 32'(len_q));
    assign last_beat = (beat_cnt == len_q - SIZE_W'(1));

    // FIFO storage: data path only, never reset
    always_ff @(posedge ddr3_clk) begin
        if (push) begin
            mem_data[wr_ptr] <= wd_data;
            mem_be[wr_ptr]   <= wd_be;
        end
    end

    always_ff @(posedge ddr3_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head word is forced to zero while empty so outputs are defined out of reset
    assign ddr3_avl_wr_data = (count != '0) ? mem_data[rd_ptr] : '0;
    assign ddr3_avl_be      = (count != '0) ? mem_be[rd_ptr]   : '0;

    always_ff @(posedge ddr3_clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
            cmd_err_q <= 1'b0;
        end else begin
            state     <= state_nx;
            cmd_err_q <= cmd_fire & ~len_ok;
            if (cmd_fire && len_ok) begin
                addr_q   <= cmd_addr;
                len_q    <= cmd_len;
                beat_cnt <= '0;
            end else if (pop) begin
                beat_cnt <= beat_cnt + SIZE_W'(1);
            end
        end
    end

    // A burst only starts once the whole burst is buffered, so write_req never gaps
    always_comb begin
        state_nx            = state;
        ddr3_avl_write_req  = 1'b0;
        ddr3_avl_burstbegin = 1'b0;
        wr_done             = 1'b0;
        case (state)
            IDLE:  if (cmd_fire && len_ok) state_nx = FILL;
            FILL:  if (fill_ok) state_nx = BURST;
            BURST: begin
                ddr3_avl_write_req  = 1'b1;
                ddr3_avl_burstbegin = (beat_cnt == '0);
                if (ddr3_avl_ready && last_beat) state_nx = DONE;
            end
            DONE: begin
                wr_done  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign ddr3_avl_size = len_q;
    assign ddr3_avl_addr = addr_q;
    assign busy          = (state != IDLE);
    assign cmd_err       = cmd_err_q;

endmodule
